dsp_result_decimator: RTL and testbench
=======================================

# dsp_result_decimator

Downstream stage of the DSP host FIR output. Consumes the free-running `dsp_out`/`result_valid` stream, which has no backpressure. It averages every 2^DECIM_LOG2 consecutive results into one output word and buffers the averages in a small first-word-fall-through (FWFT) FIFO. A consumer drains the FIFO through a valid/ready handshake. Results that arrive when the FIFO is full are dropped and flagged through a sticky overflow bit.

## Interface
Parameters:
- `IN_WIDTH`, 32 — width of the input and output data; matches the host's `DATA_WIDTH*2`.
- `DECIM_LOG2`, 2 — log2 of the decimation factor D; legal range 1..8.
- `FIFO_DEPTH`, 4 — number of output FIFO entries; must be a power of two, 2..64.

Ports (the clock is `clk`; reset is asynchronous, active-low `rst_n`):
- `clk`  in  1  — the single clock; all logic is rising-edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `in_data`  in  IN_WIDTH  — unsigned FIR result; connects to `dsp_out`.
- `in_valid`  in  1  — input strobe; connects to `result_valid`.
- `flush`  in  1  — synchronous; discards the partial accumulation.
- `clr_ovf`  in  1  — synchronous; clears `overflow`.
- `out_data`  out  IN_WIDTH  — FIFO head; forced to 0 when the FIFO is empty.
- `out_valid`  out  1  — high while the FIFO is not empty.
- `out_ready`  in  1  — consumer accept.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  — current occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  — sticky flag: at least one average was dropped.

## Operation
- State: accumulator `acc` (IN_WIDTH+DECIM_LOG2 bits), sample counter `cnt` (DECIM_LOG2 bits), FIFO memory, read/write pointers, occupancy count.
- Accumulation phases, tracked by `cnt`:
  - ACCUM (`cnt` < D-1): on `in_valid`, `acc` += `in_data` and `cnt`++.
  - EMIT (`cnt` == D-1): on `in_valid`, form `sum` = `acc` + `in_data` (computed IN_WIDTH+DECIM_LOG2+1 bits wide), push the average `sum` >> DECIM_LOG2 to the FIFO, then reset `acc` and `cnt` to 0.
- No `in_valid`: `acc` and `cnt` hold.
- `flush` in a cycle: `acc` and `cnt` go to 0. If `in_valid` is also high, that sample is discarded; `flush` wins. The FIFO is unaffected.
- Pop: occurs when `out_valid` && `out_ready`. The head advances at that edge.
- Push when the FIFO is full and there is no pop: the average is dropped and `overflow` is set to 1.
- Push and pop in the same cycle: both occur and `fifo_level` is unchanged. This applies when the FIFO is full, and the push is then not dropped. When the FIFO is empty, a same-cycle pop is impossible because `out_valid` is 0.
- `overflow`: set has priority over `clr_ovf` in the same cycle. Otherwise `clr_ovf` clears it.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` counts 0..FIFO_DEPTH inclusive, so full and empty are distinguishable.
- Arithmetic: the average always fits in IN_WIDTH bits; this holds even at the all-ones input with rounding enabled.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fifo_level`=0, `overflow`=0, `acc`=0, `cnt`=0, pointers=0.
- Reset asserted mid-operation: the partial average and all FIFO contents are lost immediately (asynchronous).
- Latency: the D-th valid sample is sampled at edge N. `out_valid` and `out_data` show the average after edge N, provided the FIFO was empty. This is 1 cycle.
- Throughput: one average per D input strobes. The pop rate is one word per cycle.
- `out_data` and `out_valid` hold stable while `out_valid`=1 and `out_ready`=0.
- `fifo_level` and `overflow` update at the same edge as the push or pop that changes them.

## Configuration
- Macro: `DSP_DECIM_ROUND_EN`.
- Defined: round-half-up, average = (`sum` + 2^(DECIM_LOG2-1)) >> DECIM_LOG2.
- Undefined: truncation, average = `sum` >> DECIM_LOG2.
- No other behaviour differs between the two builds.

## Test plan
Defaults throughout (D=4, FIFO_DEPTH=4).
1. Inputs 10, 20, 30, 42 on consecutive cycles with `out_ready`=1 -> one output: 25 truncated, 26 with `DSP_DECIM_ROUND_EN`. `out_valid` rises 1 cycle after the 4th sample, and `fifo_level` returns to 0 after the pop.
2. Four inputs of 0xFFFFFFFF -> output 0xFFFFFFFF in both builds; no wrap.
3. `out_ready`=0, 20 samples (5 averages) -> `fifo_level`=4, `overflow`=1, and the FIFO holds the first 4 averages in order. Then `clr_ovf` pulse -> `overflow`=0, and draining returns those 4 averages.
4. FIFO full, with the 4th sample of a block arriving in the same cycle as a pop -> `fifo_level` stays 4, `overflow` stays 0, and the new average lands at the tail.
5. Samples 100, 100, then `flush` together with `in_valid` on a third sample, then 4, 8, 12, 16 -> only output 10; the first two samples and the flushed sample contribute nothing.
6. `rst_n` pulsed low with 2 entries buffered and `cnt`=3 -> all outputs return to reset values immediately. The next 4 samples 1, 1, 1, 1 give exactly one output, 1.

Source files
------------

// File: rtl/dsp_result_decimator.sv
// Averages every 2^DECIM_LOG2 input results and buffers the averages in a FWFT FIFO.
// Optional build macro: DSP_DECIM_ROUND_EN selects round-half-up instead of truncation.
module dsp_result_decimator #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IN_WIDTH-1:0]                  in_data,
    input  logic                                 in_valid,
    input  logic                                 flush,
    input  logic                                 clr_ovf,
    output logic [IN_WIDTH-1:0]                  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 overflow
);

    localparam int unsigned ACC_W = IN_WIDTH + DECIM_LOG2;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = $clog2(FIFO_DEPTH + 1);

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [IN_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [IN_WIDTH-1:0]   mem_d [FIFO_DEPTH];

    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      sum_adj;
    logic [IN_WIDTH-1:0]   avg;
    logic                  push_req;
    logic                  pop;
    logic                  full;
    logic                  drop;
    logic                  push_ok;

    // Sum is one bit wider than acc so the rounding bias cannot wrap at all-ones input.
    always_comb begin
        sum = SUM_W'(acc_q) + SUM_W'(in_data);
`ifdef DSP_DECIM_ROUND_EN
        sum_adj = sum + (SUM_W'(1) << (DECIM_LOG2 - 1));
`else
        sum_adj = sum;
`endif
        avg = IN_WIDTH'(sum_adj >> DECIM_LOG2);
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        push_req = 1'b0;
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (cnt_q == '1) begin
                push_req = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = acc_q + ACC_W'(in_data);
                cnt_d = cnt_q + DECIM_LOG2'(1);
            end
        end
    end

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = (level_q != '0) && out_ready;
    assign drop    = push_req && full && !pop;
    assign push_ok = push_req && !drop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = avg;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as clr_ovf still leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_dsp_result_decimator.sv
// Scoreboard bench for dsp_result_decimator at default parameters (D=4, depth 4).
module tb_dsp_result_decimator;

    localparam int unsigned W     = 32;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned D     = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic          overflow;

    int            n_checks = 0;
    int            n_errors = 0;
    logic          chk_en = 1'b0;

    logic [63:0]   m_acc;
    int unsigned   m_cnt;
    logic          m_ovf;
    logic [W-1:0]  sb[$];

    int            dut_pops = 0;
    logic [W-1:0]  dut_last = '0;

    dsp_result_decimator #(
        .IN_WIDTH   (W),
        .DECIM_LOG2 (DL2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] avg_of(input logic [63:0] s);
`ifdef DSP_DECIM_ROUND_EN
        return W'((s + 64'(D / 2)) / 64'(D));
`else
        return W'(s / 64'(D));
`endif
    endfunction

    // Reference model: expected averages enter the scoreboard at the edge the DUT pushes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0;
            m_cnt <= 0;
            m_ovf <= 1'b0;
            sb.delete();
        end else begin
            automatic logic         do_pop  = (sb.size() != 0) && out_ready;
            automatic logic         do_push = 1'b0;
            automatic logic [W-1:0] a       = '0;
            if (flush) begin
                m_acc <= '0;
                m_cnt <= 0;
            end else if (in_valid) begin
                if (m_cnt == D - 1) begin
                    do_push = 1'b1;
                    a       = avg_of(m_acc + 64'(in_data));
                    m_acc <= '0;
                    m_cnt <= 0;
                end else begin
                    m_acc <= m_acc + 64'(in_data);
                    m_cnt <= m_cnt + 1;
                end
            end
            if (do_push && sb.size() == DEPTH && !do_pop) begin
                m_ovf   <= 1'b1;
                do_push = 1'b0;
            end else if (clr_ovf) begin
                m_ovf <= 1'b0;
            end
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(a);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            check_eq("fifo_level", 64'(fifo_level), 64'(sb.size()));
            check_eq("overflow", 64'(overflow), 64'(m_ovf));
            check_eq("out_data", 64'(out_data), (sb.size() != 0) ? 64'(sb[0]) : 64'd0);
            if (out_valid && out_ready) begin
                dut_pops++;
                dut_last = out_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out_data", 64'(out_data), 64'd0);
        check_eq("reset_level", 64'(fifo_level), 64'd0);
        check_eq("reset_overflow", 64'(overflow), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // 1: basic average, 1-cycle latency, pop
        out_ready = 1'b1;
        send(32'd10); send(32'd20); send(32'd30);
        check_eq("t1_no_early_valid", 64'(out_valid), 64'd0);
        send(32'd42);
        check_eq("t1_valid_after_4th", 64'(out_valid), 64'd1);
`ifdef DSP_DECIM_ROUND_EN
        check_eq("t1_value_early", 64'(out_data), 64'd26);
`else
        check_eq("t1_value_early", 64'(out_data), 64'd25);
`endif
        tick(1);
`ifdef DSP_DECIM_ROUND_EN
        check_eq("t1_popped", 64'(dut_last), 64'd26);
`else
        check_eq("t1_popped", 64'(dut_last), 64'd25);
`endif
        check_eq("t1_level_zero", 64'(fifo_level), 64'd0);

        // 2: all-ones input must not wrap
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
        tick(1);
        check_eq("t2_all_ones", 64'(dut_last), 64'hFFFF_FFFF);

        // 3: overflow with consumer stalled, then clear and drain
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) send(W'(3 * k + 1));
        check_eq("t3_level_full", 64'(fifo_level), 64'd4);
        check_eq("t3_overflow_set", 64'(overflow), 64'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_eq("t3_overflow_clr", 64'(overflow), 64'd0);
        dut_pops = 0;
        out_ready = 1'b1;
        tick(4);
        out_ready = 1'b0;
        check_eq("t3_drain_count", 64'(dut_pops), 64'd4);
`ifdef DSP_DECIM_ROUND_EN
        check_eq("t3_last_avg", 64'(dut_last), 64'd42);
`else
        check_eq("t3_last_avg", 64'(dut_last), 64'd41);
`endif

        // 4: push while full coinciding with a pop
        for (int k = 0; k < 16; k++) send(32'd8);
        check_eq("t4_full", 64'(fifo_level), 64'd4);
        send(32'd40); send(32'd40); send(32'd40);
        out_ready = 1'b1;
        send(32'd40);
        out_ready = 1'b0;
        check_eq("t4_level_kept", 64'(fifo_level), 64'd4);
        check_eq("t4_no_overflow", 64'(overflow), 64'd0);
        dut_pops = 0;
        out_ready = 1'b1;
        tick(4);
        check_eq("t4_drain_count", 64'(dut_pops), 64'd4);
        check_eq("t4_tail_value", 64'(dut_last), 64'd40);
        check_eq("t4_empty", 64'(fifo_level), 64'd0);

        // 5: flush discards partial block and the coincident sample
        dut_pops = 0;
        send(32'd100); send(32'd100);
        flush = 1'b1;
        send(32'd100);
        flush = 1'b0;
        send(32'd4); send(32'd8); send(32'd12); send(32'd16);
        tick(2);
        check_eq("t5_one_output", 64'(dut_pops), 64'd1);
        check_eq("t5_value", 64'(dut_last), 64'd10);

        // 6: asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(32'd5);
        send(32'd7); send(32'd7); send(32'd7);
        check_eq("t6_buffered", 64'(fifo_level), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_data", 64'(out_data), 64'd0);
        check_eq("t6_rst_level", 64'(fifo_level), 64'd0);
        check_eq("t6_rst_ovf", 64'(overflow), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        dut_pops = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(32'd1);
        tick(3);
        check_eq("t6_one_output", 64'(dut_pops), 64'd1);
        check_eq("t6_value", 64'(dut_last), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
